// File: rtl/alctrl_ram_gated.sv
// Active-list control RAM in NUM_PARTS power-gated partitions, each swept clean by its own OFF/CLEAR/ON FSM.
// Latency: writes land at the edge; reads are combinational, or one cycle when ALCTRL_RD_REG_EN is defined.
// Backpressure: none; writes to non-ON partitions are dropped, gated lanes/partitions read 0/CLR_VALUE.
module alctrl_ram_gated #(
    parameter int RPORT         = 4,
    parameter int WPORT         = 8,
    parameter int DEPTH         = 128,
    parameter int INDEX         = 7,
    parameter int WIDTH         = 8,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RPORT*INDEX-1:0] raddr_i,
    output logic [RPORT*WIDTH-1:0] rdata_o,
    input  logic [WPORT*INDEX-1:0] waddr_i,
    input  logic [WPORT*WIDTH-1:0] wdata_i,
    input  logic [WPORT-1:0]       we_i,
    input  logic [WPORT-1:0]       issueLaneActive_i,
    input  logic [RPORT-1:0]       commitLaneActive_i,
    input  logic [NUM_PARTS-1:0]   alPartitionActive_i,
    output logic [NUM_PARTS-1:0]   partReady_o,
    output logic                   alCtrlReady_o
);

    localparam int PDEPTH = DEPTH / NUM_PARTS;
    localparam int ROWW   = INDEX - NUM_PARTS_LOG;
    localparam int PSW    = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;
    localparam logic [ROWW-1:0] LAST_ROW = ROWW'(PDEPTH - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    state_e                 state_q   [NUM_PARTS];
    state_e                 state_d   [NUM_PARTS];
    logic [ROWW-1:0]        clr_cnt_q [NUM_PARTS];
    logic [ROWW-1:0]        clr_cnt_d [NUM_PARTS];
    logic [INDEX-1:0]       clr_addr  [NUM_PARTS];
    logic [NUM_PARTS-1:0]   part_on;

    logic [INDEX-1:0]       waddr     [WPORT];
    logic [WPORT-1:0]       wr_hit;
    logic [INDEX-1:0]       raddr     [RPORT];
    logic [RPORT*WIDTH-1:0] rdata_d;

    logic [WIDTH-1:0]       mem       [DEPTH];

    // Shifting rather than slicing keeps the single-partition build (zero select bits) legal.
    function automatic logic [PSW-1:0] part_sel(input logic [INDEX-1:0] a);
        return PSW'(a >> ROWW);
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            state_d[p]   = state_q[p];
            clr_cnt_d[p] = clr_cnt_q[p];
            unique case (state_q[p])
                ST_OFF: begin
                    if (alPartitionActive_i[p]) begin
                        state_d[p]   = ST_CLEAR;
                        clr_cnt_d[p] = '0;
                    end
                end
                ST_CLEAR: begin
                    if (!alPartitionActive_i[p]) begin
                        state_d[p]   = ST_OFF;
                        clr_cnt_d[p] = '0;
                    end else if (clr_cnt_q[p] == LAST_ROW) begin
                        state_d[p]   = ST_ON;
                        clr_cnt_d[p] = '0;
                    end else begin
                        clr_cnt_d[p] = clr_cnt_q[p] + 1'b1;
                    end
                end
                ST_ON: begin
                    if (!alPartitionActive_i[p]) begin
                        state_d[p] = ST_OFF;
                    end
                end
                default: begin
                    state_d[p]   = ST_OFF;
                    clr_cnt_d[p] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                state_q[p]   <= ST_OFF;
                clr_cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                state_q[p]   <= state_d[p];
                clr_cnt_q[p] <= clr_cnt_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            part_on[p]  = (state_q[p] == ST_ON);
            clr_addr[p] = INDEX'(p * PDEPTH) + INDEX'(clr_cnt_q[p]);
        end
    end

    assign partReady_o = part_on;

    // Settled means every partition has reached the state its enable asks for.
    always_comb begin
        alCtrlReady_o = 1'b1;
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (alPartitionActive_i[p]) begin
                alCtrlReady_o = alCtrlReady_o & part_on[p];
            end else begin
                alCtrlReady_o = alCtrlReady_o & (state_q[p] == ST_OFF);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < WPORT; w++) begin
            waddr[w]  = waddr_i[w*INDEX +: INDEX];
            wr_hit[w] = issueLaneActive_i[w] & we_i[w] & part_on[part_sel(waddr[w])];
        end
    end

    // Later loop iterations override earlier ones, so the highest port wins a row collision.
    // Sweep writes never collide with functional writes: they target partitions that are not ON.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WPORT; w++) begin
            if (wr_hit[w]) begin
                mem[waddr[w]] <= wdata_i[w*WIDTH +: WIDTH];
            end
        end
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (state_q[p] == ST_CLEAR) begin
                mem[clr_addr[p]] <= CLR_VALUE;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int r = 0; r < RPORT; r++) begin
            raddr[r] = raddr_i[r*INDEX +: INDEX];
            if (!commitLaneActive_i[r]) begin
                rdata_d[r*WIDTH +: WIDTH] = '0;
            end else if (!part_on[part_sel(raddr[r])]) begin
                rdata_d[r*WIDTH +: WIDTH] = CLR_VALUE;
            end else begin
                rdata_d[r*WIDTH +: WIDTH] = mem[raddr[r]];
            end
        end
    end

`ifdef ALCTRL_RD_REG_EN
    logic [RPORT*WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
`else
    assign rdata_o = rdata_d;
`endif

endmodule

// File: tb/tb_alctrl_ram_gated.sv
// Bench for alctrl_ram_gated: activation sweeps, write/read rules, lane gating, sweep abort, reset mid-sweep.
module tb_alctrl_ram_gated;

    localparam int RPORT = 4;
    localparam int WPORT = 8;
    localparam int INDEX = 7;
    localparam int WIDTH = 8;
    localparam int NP    = 4;
    localparam int PDEPTH = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [RPORT*INDEX-1:0] raddr_i;
    logic [RPORT*WIDTH-1:0] rdata_o;
    logic [WPORT*INDEX-1:0] waddr_i;
    logic [WPORT*WIDTH-1:0] wdata_i;
    logic [WPORT-1:0]       we_i;
    logic [WPORT-1:0]       issueLaneActive_i;
    logic [RPORT-1:0]       commitLaneActive_i;
    logic [NP-1:0]          alPartitionActive_i;
    logic [NP-1:0]          partReady_o;
    logic                   alCtrlReady_o;

    always #5 clk = ~clk;

    alctrl_ram_gated dut (
        .clk                 (clk),
        .reset               (reset),
        .raddr_i             (raddr_i),
        .rdata_o             (rdata_o),
        .waddr_i             (waddr_i),
        .wdata_i             (wdata_i),
        .we_i                (we_i),
        .issueLaneActive_i   (issueLaneActive_i),
        .commitLaneActive_i  (commitLaneActive_i),
        .alPartitionActive_i (alPartitionActive_i),
        .partReady_o         (partReady_o),
        .alCtrlReady_o       (alCtrlReady_o)
    );

    int checks = 0;
    int errors = 0;
    logic acr_hi;

    typedef struct {
        int         port;
        logic [7:0] exp;
        string      name;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        int         wp;
        logic [6:0] wa;
        logic [7:0] wd;
        logic       iss;
        int         rp;
        logic       com;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input int port, input logic [7:0] exp, input string name);
        rd_exp_t e;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        rd_exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, 32'(rdata_o[e.port*WIDTH +: WIDTH]), 32'(e.exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int w, input logic [6:0] a, input logic [7:0] d);
        we_i[w] = 1'b1;
        waddr_i[w*INDEX +: INDEX] = a;
        wdata_i[w*WIDTH +: WIDTH] = d;
    endtask

    task automatic set_rd(input int r, input logic [6:0] a);
        raddr_i[r*INDEX +: INDEX] = a;
    endtask

    // n counts edges, with the edge that samples the activation as edge 1.
    task automatic wait_ready(input logic [NP-1:0] mask, inout int n);
        while (((partReady_o & mask) != mask) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (alCtrlReady_o && ((partReady_o & mask) != mask)) acr_hi = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vt[0] = '{wp: 0, wa: 7'h22, wd: 8'hA5, iss: 1'b1, rp: 1, com: 1'b1, exp: 8'hA5};
        vt[1] = '{wp: 3, wa: 7'h02, wd: 8'h7F, iss: 1'b0, rp: 2, com: 1'b1, exp: 8'h00};
        vt[2] = '{wp: 7, wa: 7'h3F, wd: 8'h5A, iss: 1'b1, rp: 3, com: 1'b1, exp: 8'h5A};
        vt[3] = '{wp: 6, wa: 7'h20, wd: 8'hC3, iss: 1'b1, rp: 0, com: 1'b0, exp: 8'h00};
        vt[4] = '{wp: 1, wa: 7'h45, wd: 8'hEE, iss: 1'b1, rp: 0, com: 1'b1, exp: 8'h00};
        vt[5] = '{wp: 4, wa: 7'h00, wd: 8'h3C, iss: 1'b1, rp: 0, com: 1'b1, exp: 8'h3C};
        vt[6] = '{wp: 2, wa: 7'h20, wd: 8'h99, iss: 1'b1, rp: 3, com: 1'b1, exp: 8'h99};
        vt[7] = '{wp: 5, wa: 7'h7F, wd: 8'h81, iss: 1'b1, rp: 1, com: 1'b1, exp: 8'h00};

        reset = 1'b0;
        raddr_i = '0;
        waddr_i = '0;
        wdata_i = '0;
        we_i = '0;
        issueLaneActive_i = '1;
        commitLaneActive_i = '1;
        alPartitionActive_i = '0;
        acr_hi = 1'b0;

        #1;
        check("rst_partReady", 32'(partReady_o), 32'h0);
        check("rst_alCtrlReady_idle", 32'(alCtrlReady_o), 32'h1);
        alPartitionActive_i = 4'b0011;
        #1;
        check("rst_alCtrlReady_act", 32'(alCtrlReady_o), 32'h0);
        for (int r = 0; r < RPORT; r++) expect_rd(r, 8'h00, $sformatf("rst_rd%0d", r));
        drain();

        tick();
        tick();
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) tick();
        n = 5;
        check("sweep_partReady_low", 32'(partReady_o), 32'h0);
        set_rd(0, 7'h00); set_rd(1, 7'h10); set_rd(2, 7'h21); set_rd(3, 7'h3F);
        #1;
        for (int r = 0; r < RPORT; r++) expect_rd(r, 8'h00, $sformatf("sweep_rd%0d", r));
        drain();
        wait_ready(4'b0011, n);
        check("act_latency", 32'(n), 32'(PDEPTH + 1));
        check("act_partReady", 32'(partReady_o), 32'h3);
        check("act_alCtrlReady", 32'(alCtrlReady_o), 32'h1);
        set_rd(0, 7'h00); set_rd(1, 7'h1F); set_rd(2, 7'h20); set_rd(3, 7'h3F);
        #1;
        for (int r = 0; r < RPORT; r++) expect_rd(r, 8'h00, $sformatf("cleared_rd%0d", r));
        drain();

        // Read-during-write returns old data; new data visible the next cycle.
        tick();
        set_wr(0, 7'h21, 8'hA5);
        set_rd(1, 7'h21);
        #1;
        expect_rd(1, 8'h00, "rdw_old");
        drain();
        tick();
        we_i = '0;
        #1;
        expect_rd(1, 8'hA5, "rdw_new");
        drain();

        // Highest-numbered port wins a same-row collision, in either port ordering.
        tick();
        set_wr(2, 7'h05, 8'h11);
        set_wr(5, 7'h05, 8'h22);
        set_wr(1, 7'h06, 8'h44);
        set_wr(6, 7'h06, 8'h33);
        tick();
        we_i = '0;
        set_rd(2, 7'h05);
        set_rd(3, 7'h06);
        #1;
        expect_rd(2, 8'h22, "prio_2v5");
        expect_rd(3, 8'h33, "prio_1v6");
        drain();

        for (int i = 0; i < 8; i++) begin
            tick();
            we_i = '0;
            issueLaneActive_i = '1;
            set_wr(vt[i].wp, vt[i].wa, vt[i].wd);
            issueLaneActive_i[vt[i].wp] = vt[i].iss;
            expect_rd(vt[i].rp, vt[i].exp, $sformatf("vec%0d", i));
            tick();
            we_i = '0;
            issueLaneActive_i = '1;
            set_rd(vt[i].rp, vt[i].wa);
            commitLaneActive_i = '1;
            commitLaneActive_i[vt[i].rp] = vt[i].com;
            #1;
            drain();
            commitLaneActive_i = '1;
        end

        // Sweep abort on partition 2, then restart from row 0.
        tick();
        acr_hi = 1'b0;
        alPartitionActive_i = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (alCtrlReady_o) acr_hi = 1'b1;
        end
        alPartitionActive_i = 4'b0011;
        check("abort_partReady2_low", 32'(partReady_o[2]), 32'h0);
        tick();
        tick();
        tick();
        alPartitionActive_i = 4'b0111;
        n = 0;
        wait_ready(4'b0100, n);
        check("abort_restart_latency", 32'(n), 32'(PDEPTH + 1));
        check("abort_alCtrlReady_low", 32'(acr_hi), 32'h0);
        check("abort_partReady", 32'(partReady_o), 32'h7);
        check("abort_alCtrlReady_end", 32'(alCtrlReady_o), 32'h1);
        set_rd(0, 7'h05);
        set_rd(1, 7'h45);
        #1;
        expect_rd(0, 8'h22, "abort_p0_kept");
        expect_rd(1, 8'h00, "abort_p2_cleared");
        drain();

        // Deactivation: partReady falls one edge after active is sampled low.
        tick();
        alPartitionActive_i = 4'b0110;
        #1;
        check("deact_partReady_before", 32'(partReady_o), 32'h7);
        check("deact_alCtrlReady_before", 32'(alCtrlReady_o), 32'h0);
        tick();
        check("deact_partReady_after", 32'(partReady_o), 32'h6);
        check("deact_alCtrlReady_after", 32'(alCtrlReady_o), 32'h1);

        // Reset asserted mid-sweep.
        tick();
        alPartitionActive_i = 4'b1111;
        for (int k = 0; k < 5; k++) tick();
        check("midrst_partReady_sweeping", 32'(partReady_o), 32'h6);
        reset = 1'b0;
        #1;
        check("midrst_partReady", 32'(partReady_o), 32'h0);
        check("midrst_alCtrlReady", 32'(alCtrlReady_o), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        n = 0;
        wait_ready(4'b1111, n);
        check("midrst_latency", 32'(n), 32'(PDEPTH + 1));
        check("midrst_alCtrlReady_end", 32'(alCtrlReady_o), 32'h1);
        set_rd(0, 7'h05);
        set_rd(1, 7'h7F);
        set_rd(2, 7'h45);
        #1;
        expect_rd(0, 8'h00, "midrst_p0_recleared");
        expect_rd(1, 8'h00, "midrst_p3_cleared");
        expect_rd(2, 8'h00, "midrst_p2_recleared");
        drain();
        tick();
        set_wr(7, 7'h7F, 8'h81);
        tick();
        we_i = '0;
        #1;
        expect_rd(1, 8'h81, "midrst_p3_write");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
